// File: rtl/change_dispenser.sv
// change_dispenser: coin-return back end. Captures per-denomination change
// counts, keeps a stock counter per coin tube, ejects coins one at a time over
// a 4-phase handshake, and substitutes smaller coins when a tube runs empty.
// Any value that still cannot be paid is reported as a shortfall.
module change_dispenser #(
  parameter int STOCK_W    = 4,
  parameter int STOCK_INIT = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [2:0]         rs_5,
  input  logic [2:0]         rs_10,
  input  logic [2:0]         rs_20,
  input  logic [2:0]         rs_50,
  input  logic [2:0]         rs_100,
  input  logic               refill,
  input  logic               eject_ack,
  output logic [4:0]         eject,
  output logic               busy,
  output logic               done,
  output logic               short,
  output logic [10:0]        short_amount,
  output logic [STOCK_W-1:0] stock_5,
  output logic [STOCK_W-1:0] stock_10,
  output logic [STOCK_W-1:0] stock_20,
  output logic [STOCK_W-1:0] stock_50,
  output logic [STOCK_W-1:0] stock_100
);

  localparam int                 NUM_DENOM = 5;
  localparam logic [STOCK_W-1:0] STOCK_MAX = {STOCK_W{1'b1}};
  localparam logic [STOCK_W-1:0] STOCK_RST = STOCK_W'(STOCK_INIT);
  localparam logic [STOCK_W-1:0] STOCK_ONE = STOCK_W'(1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PICK    = 3'd1,
    EJECT   = 3'd2,
    RELEASE = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t state;

  // Index 0..4 maps to Rs5, Rs10, Rs20, Rs50, Rs100 (same as eject bit order).
  // 9 bits: cascaded substitution can push pending Rs5 to 259.
  logic [8:0]         pending [NUM_DENOM];
  logic [STOCK_W-1:0] stock   [NUM_DENOM];

  logic [2:0]         sel;
  logic               sel_valid;
  logic [8:0]         sel_pending;
  logic [STOCK_W-1:0] sel_stock;

  // Highest denomination with coins still owed; later (larger) entries win.
  always_comb begin
    sel       = 3'd0;
    sel_valid = 1'b0;
    for (int i = 0; i < NUM_DENOM; i++) begin
      sel       = (pending[i] != 9'd0) ? 3'(i) : sel;
      sel_valid = sel_valid | (pending[i] != 9'd0);
    end
    sel_pending = pending[sel];
    sel_stock   = stock[sel];
  end

  assign stock_5   = stock[0];
  assign stock_10  = stock[1];
  assign stock_20  = stock[2];
  assign stock_50  = stock[3];
  assign stock_100 = stock[4];

  // Transaction FSM with registered outputs, pending and stock bookkeeping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      eject        <= 5'd0;
      busy         <= 1'b0;
      done         <= 1'b0;
      short        <= 1'b0;
      short_amount <= 11'd0;
      for (int i = 0; i < NUM_DENOM; i++) begin
        pending[i] <= 9'd0;
        stock[i]   <= STOCK_RST;
      end
    end else begin
      case (state)
        IDLE: begin
          done  <= 1'b0;
          eject <= 5'd0;
          if (refill) begin
            for (int i = 0; i < NUM_DENOM; i++) begin
              stock[i] <= STOCK_MAX;
            end
          end
          if (load) begin
            pending[0]   <= 9'(rs_5);
            pending[1]   <= 9'(rs_10);
            pending[2]   <= 9'(rs_20);
            pending[3]   <= 9'(rs_50);
            pending[4]   <= 9'(rs_100);
            short        <= 1'b0;
            short_amount <= 11'd0;
            busy         <= 1'b1;
            state        <= PICK;
          end
        end

        PICK: begin
          if (!sel_valid) begin
            // Nothing owed: short_amount is final, so publish it with done.
            done  <= 1'b1;
            short <= (short_amount != 11'd0);
            state <= DONE;
          end else if (sel_stock != '0) begin
            eject <= 5'd1 << sel;
            state <= EJECT;
          end else begin
            // Tube empty: break the owed coins into the next smaller ones.
            case (sel)
              3'd4: pending[3] <= pending[3] + (sel_pending << 1);
              3'd3: begin
                pending[2] <= pending[2] + (sel_pending << 1);
                pending[1] <= pending[1] + sel_pending;
              end
              3'd2: pending[1] <= pending[1] + (sel_pending << 1);
              3'd1: pending[0] <= pending[0] + (sel_pending << 1);
              // Rs5 has nothing smaller: the value becomes shortfall.
              default: short_amount <= short_amount + (11'(sel_pending) * 11'd5);
            endcase
            pending[sel] <= 9'd0;
          end
        end

        EJECT: begin
          // sel is stable here: pending does not change until the ack.
          if (eject_ack) begin
            pending[sel] <= sel_pending - 9'd1;
            stock[sel]   <= sel_stock - STOCK_ONE;
            eject        <= 5'd0;
            state        <= RELEASE;
          end
        end

        RELEASE: begin
          if (!eject_ack) begin
            state <= PICK;
          end
        end

        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          eject <= 5'd0;
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser: stimulus pushes expected eject codes
// and transaction results; a negedge monitor pops and compares them.
module tb_change_dispenser;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [2:0]  rs_5, rs_10, rs_20, rs_50, rs_100;
  logic        refill;
  logic        eject_ack;
  logic [4:0]  eject;
  logic        busy, done, short;
  logic [10:0] short_amount;
  logic [3:0]  stock_5, stock_10, stock_20, stock_50, stock_100;

  logic        auto_ack = 1'b0;
  logic        resp_ack = 1'b0;
  logic        man_ack  = 1'b0;
  assign eject_ack = auto_ack ? resp_ack : man_ack;

  int total = 0;
  int bad   = 0;

  logic [4:0]  exp_ej   [$];
  logic [11:0] exp_done [$];
  logic [4:0]  prev_ej = 5'd0;

  change_dispenser #(.STOCK_W(4), .STOCK_INIT(8)) dut (
    .clk(clk), .rst(rst), .load(load),
    .rs_5(rs_5), .rs_10(rs_10), .rs_20(rs_20), .rs_50(rs_50), .rs_100(rs_100),
    .refill(refill), .eject_ack(eject_ack), .eject(eject), .busy(busy),
    .done(done), .short(short), .short_amount(short_amount),
    .stock_5(stock_5), .stock_10(stock_10), .stock_20(stock_20),
    .stock_50(stock_50), .stock_100(stock_100)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [19:0] stk(input int a100, input int a50, input int a20,
                                      input int a10, input int a5);
    return {4'(a100), 4'(a50), 4'(a20), 4'(a10), 4'(a5)};
  endfunction

  task automatic check_stock(input string name, input logic [19:0] exp);
    check(name, 32'({stock_100, stock_50, stock_20, stock_10, stock_5}), 32'(exp));
  endtask

  // Monitor: compare each new eject request and each done pulse.
  always @(negedge clk) begin
    if (rst && eject != 5'd0 && prev_ej == 5'd0) begin
      check("eject_onehot", 32'($onehot(eject)), 32'd1);
      if (exp_ej.size() == 0) check("eject_unexpected", 32'(eject), 32'd0);
      else check("eject_code", 32'(eject), 32'(exp_ej.pop_front()));
    end
    if (done) begin
      if (exp_done.size() == 0) check("done_unexpected", 32'(done), 32'd0);
      else check("done_result", 32'({short, short_amount}), 32'(exp_done.pop_front()));
    end
    prev_ej = eject;
  end

  // Mechanism model: acknowledge each request two cycles after it appears.
  initial begin
    forever begin
      @(negedge clk);
      if (auto_ack && eject != 5'd0 && !resp_ack) begin
        repeat (2) @(negedge clk);
        resp_ack = 1'b1;
        @(negedge clk);
        resp_ack = 1'b0;
      end
    end
  end

  task automatic do_load(input logic [2:0] a5, input logic [2:0] a10, input logic [2:0] a20,
                         input logic [2:0] a50, input logic [2:0] a100);
    @(negedge clk);
    rs_5 = a5; rs_10 = a10; rs_20 = a20; rs_50 = a50; rs_100 = a100;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    rs_5 = 3'd0; rs_10 = 3'd0; rs_20 = 3'd0; rs_50 = 3'd0; rs_100 = 3'd0;
    check("busy_after_load", 32'(busy), 32'd1);
  endtask

  task automatic wait_done(output int cyc);
    bit seen;
    seen = 1'b0;
    cyc  = 0;
    for (int i = 1; i <= 400 && !seen; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        cyc  = i;
      end
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL done_timeout: got no done want done within 400 cycles");
    end
    @(negedge clk);
    check("idle_after_done", 32'({busy, done}), 32'd0);
  endtask

  task automatic wait_eject();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = (eject != 5'd0);
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL eject_timeout: got no eject want eject within 20 cycles");
    end
  endtask

  initial begin
    int cyc;
    rst = 1'b0; load = 1'b0; refill = 1'b0;
    rs_5 = 3'd0; rs_10 = 3'd0; rs_20 = 3'd0; rs_50 = 3'd0; rs_100 = 3'd0;
    repeat (2) @(negedge clk);
    check("reset_ctrl", 32'({eject, busy, done, short}), 32'd0);
    check("reset_short_amount", 32'(short_amount), 32'd0);
    check_stock("reset_stock", stk(8, 8, 8, 8, 8));
    rst = 1'b1;
    auto_ack = 1'b1;

    // Basic return: Rs20 then Rs5, with the load-to-eject latency checked.
    exp_ej.push_back(5'b00100); exp_ej.push_back(5'b00001);
    exp_done.push_back(12'd0);
    do_load(3'd1, 3'd0, 3'd1, 3'd0, 3'd0);
    check("eject_in_pick", 32'(eject), 32'd0);
    @(negedge clk);
    check("first_eject_latency", 32'(eject), 32'b00100);
    wait_done(cyc);
    check_stock("stock_basic", stk(8, 8, 7, 8, 7));

    // Ordering: highest denomination first.
    exp_ej.push_back(5'b10000); exp_ej.push_back(5'b01000);
    exp_ej.push_back(5'b00001); exp_ej.push_back(5'b00001);
    exp_done.push_back(12'd0);
    do_load(3'd2, 3'd0, 3'd0, 3'd1, 3'd1);
    wait_done(cyc);
    check_stock("stock_order", stk(7, 7, 7, 8, 5));

    // Drain the Rs100 tube.
    for (int i = 0; i < 7; i++) exp_ej.push_back(5'b10000);
    exp_done.push_back(12'd0);
    do_load(3'd0, 3'd0, 3'd0, 3'd0, 3'd7);
    wait_done(cyc);
    check_stock("stock_drain100", stk(0, 7, 7, 8, 5));

    // Substitution: one Rs100 paid as two Rs50.
    exp_ej.push_back(5'b01000); exp_ej.push_back(5'b01000);
    exp_done.push_back(12'd0);
    do_load(3'd0, 3'd0, 3'd0, 3'd0, 3'd1);
    wait_done(cyc);
    check_stock("stock_subst", stk(0, 5, 7, 8, 5));

    // Drain the Rs10 and Rs5 tubes.
    for (int i = 0; i < 7; i++) exp_ej.push_back(5'b00010);
    exp_done.push_back(12'd0);
    do_load(3'd0, 3'd7, 3'd0, 3'd0, 3'd0);
    wait_done(cyc);
    exp_ej.push_back(5'b00010);
    for (int i = 0; i < 5; i++) exp_ej.push_back(5'b00001);
    exp_done.push_back(12'd0);
    do_load(3'd5, 3'd1, 3'd0, 3'd0, 3'd0);
    wait_done(cyc);
    check_stock("stock_drain10_5", stk(0, 5, 7, 0, 0));

    // Shortfall: Rs10 -> two Rs5 -> nothing, 15 rupees short.
    exp_done.push_back({1'b1, 11'd15});
    do_load(3'd1, 3'd1, 3'd0, 3'd0, 3'd0);
    wait_done(cyc);
    check("short_held", 32'({short, short_amount}), 32'({1'b1, 11'd15}));

    // All-zero load clears short and finishes with done two cycles after load.
    exp_done.push_back(12'd0);
    do_load(3'd0, 3'd0, 3'd0, 3'd0, 3'd0);
    check("short_cleared_on_load", 32'({short, short_amount}), 32'd0);
    wait_done(cyc);
    check("zero_load_done_cycle", 32'(cyc), 32'd1);

    // Handshake stall with a load and refill attempted while busy.
    auto_ack = 1'b0;
    man_ack  = 1'b0;
    exp_ej.push_back(5'b00100);
    exp_done.push_back(12'd0);
    do_load(3'd0, 3'd0, 3'd1, 3'd0, 3'd0);
    wait_eject();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 5) begin
        rs_50 = 3'd3; load = 1'b1; refill = 1'b1;
      end else begin
        rs_50 = 3'd0; load = 1'b0; refill = 1'b0;
      end
      check("stall_eject", 32'(eject), 32'b00100);
    end
    man_ack = 1'b1;
    repeat (5) @(negedge clk);
    check("ack_held_release", 32'({eject, busy}), 32'd1);
    man_ack = 1'b0;
    wait_done(cyc);
    check_stock("stock_stall", stk(0, 5, 6, 0, 0));

    // Asynchronous reset while an eject is outstanding.
    exp_ej.push_back(5'b01000);
    do_load(3'd0, 3'd0, 3'd0, 3'd1, 3'd0);
    wait_eject();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("async_reset_ctrl", 32'({eject, busy, done, short}), 32'd0);
    check_stock("async_reset_stock", stk(8, 8, 8, 8, 8));
    @(negedge clk);
    rst = 1'b1;

    // Refill in IDLE.
    @(negedge clk);
    refill = 1'b1;
    @(negedge clk);
    refill = 1'b0;
    check_stock("stock_refill", stk(15, 15, 15, 15, 15));
    repeat (3) @(negedge clk);

    check("eject_queue_empty", 32'(exp_ej.size()), 32'd0);
    check("done_queue_empty", 32'(exp_done.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
